// File: rtl/toilet_reg_if.sv
// toilet_reg_if: host bus slave exposing controller config (CTRL), live/sticky status, events and IRQ.
// Define TOILET_REG_CNT_EN to build the saturating FLUSH_CNT/SPRAY_CNT counters and EVENT bit2.
module toilet_reg_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              bus_sel,
    input  logic              bus_wr,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [DATA_W-1:0] bus_wdata,
    output logic [DATA_W-1:0] bus_rdata,
    output logic              bus_ready,
    output logic              reg_user_en,
    output logic              reg_spray_en,
    output logic              reg_spray_mode,
    output logic              reg_auto_dis_en,
    output logic              reg_de_ur,
    input  logic              led_user,
    input  logic              spray_an,
    input  logic              user_flushes,
    input  logic              dis_ur,
    input  logic              count_spray_done,
    output logic              irq
);

    if (DATA_W < 8 || CNT_W > DATA_W) begin : g_param_check
        $error("toilet_reg_if: requires DATA_W >= 8 and CNT_W <= DATA_W");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK,
        ST_WAIT
    } state_t;

`ifdef TOILET_REG_CNT_EN
    localparam logic [2:0] IRQ_EN_MASK = 3'b111;
`else
    localparam logic [2:0] IRQ_EN_MASK = 3'b011;
`endif

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_acc;
    logic              w_ready;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [2:0]        w_addr;
    logic [4:0]        r_ctrl;
    logic [4:0]        r_s;
    logic [4:0]        r_p;
    logic [2:0]        r_event;
    logic [2:0]        r_irq_en;
    logic [2:0]        w_w1c;
    logic [2:0]        w_event_set;
    logic              w_flush_edge;
    logic              w_spray_edge;
    logic              w_sat;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] w_rd_mux;
    logic              r_irq;
    logic              w_unused;

    assign w_unused = ^{bus_addr[ADDR_W-1:3], bus_wdata[DATA_W-1:5]};

    assign w_addr   = bus_addr[2:0];
    assign w_wr_acc = w_acc & bus_wr;
    assign w_rd_acc = w_acc & ~bus_wr;

    always_comb begin
        w_state_nxt = r_state;
        w_acc       = 1'b0;
        w_ready     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus_sel) begin
                    w_acc       = 1'b1;
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                w_ready     = 1'b1;
                w_state_nxt = bus_sel ? ST_WAIT : ST_IDLE;
            end
            ST_WAIT: begin
                if (!bus_sel) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Status sample (s) and previous sample (p); edges are s & ~p.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s <= '0;
            r_p <= '0;
        end else begin
            r_s <= {count_spray_done, dis_ur, user_flushes, spray_an, led_user};
            r_p <= r_s;
        end
    end

    assign w_flush_edge = r_s[2] & ~r_p[2];
    assign w_spray_edge = r_s[4] & ~r_p[4];

`ifdef TOILET_REG_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_spray_cnt;
    logic             w_flush_clr;
    logic             w_spray_clr;
    logic             w_flush_sat;
    logic             w_spray_sat;

    assign w_flush_clr = w_wr_acc && (w_addr == 3'd4);
    assign w_spray_clr = w_wr_acc && (w_addr == 3'd5);
    // A clear overrides saturation: an edge coinciding with a clear just makes the count 1.
    assign w_flush_sat = w_flush_edge && !w_flush_clr && (r_flush_cnt == CNT_MAX);
    assign w_spray_sat = w_spray_edge && !w_spray_clr && (r_spray_cnt == CNT_MAX);
    assign w_sat       = w_flush_sat | w_spray_sat;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_flush_cnt <= '0;
            r_spray_cnt <= '0;
        end else begin
            if (w_flush_clr)
                r_flush_cnt <= CNT_W'(w_flush_edge);
            else if (w_flush_edge && (r_flush_cnt != CNT_MAX))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            if (w_spray_clr)
                r_spray_cnt <= CNT_W'(w_spray_edge);
            else if (w_spray_edge && (r_spray_cnt != CNT_MAX))
                r_spray_cnt <= r_spray_cnt + CNT_W'(1);
        end
    end
`else
    assign w_sat = 1'b0;
`endif

    assign w_w1c       = (w_wr_acc && (w_addr == 3'd2)) ? bus_wdata[2:0] : 3'b000;
    assign w_event_set = {w_sat, w_spray_edge, w_flush_edge};

    always_comb begin
        w_rd_mux = '0;
        case (w_addr)
            3'd0: w_rd_mux = DATA_W'(r_ctrl);
            3'd1: w_rd_mux = DATA_W'(r_s);
            3'd2: w_rd_mux = DATA_W'(r_event);
            3'd3: w_rd_mux = DATA_W'(r_irq_en);
`ifdef TOILET_REG_CNT_EN
            3'd4: w_rd_mux = DATA_W'(r_flush_cnt);
            3'd5: w_rd_mux = DATA_W'(r_spray_cnt);
`endif
            default: w_rd_mux = '0;
        endcase
    end

    // Register file update; hardware event set wins over a same-cycle W1C.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ctrl   <= '0;
            r_event  <= '0;
            r_irq_en <= '0;
            r_rdata  <= '0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_acc && (w_addr == 3'd0)) r_ctrl   <= bus_wdata[4:0];
            if (w_wr_acc && (w_addr == 3'd3)) r_irq_en <= bus_wdata[2:0] & IRQ_EN_MASK;
            if (w_rd_acc)                     r_rdata  <= w_rd_mux;
            r_event <= (r_event & ~w_w1c) | w_event_set;
            r_irq   <= |(r_event & r_irq_en);
        end
    end

    assign bus_rdata       = r_rdata;
    assign bus_ready       = w_ready;
    assign irq             = r_irq;
    assign reg_user_en     = r_ctrl[0];
    assign reg_spray_en    = r_ctrl[1];
    assign reg_spray_mode  = r_ctrl[2];
    assign reg_auto_dis_en = r_ctrl[3];
    assign reg_de_ur       = r_ctrl[4];

endmodule

// File: tb/tb_toilet_reg_if.sv
// Bench for toilet_reg_if: directed test-plan scenarios plus random traffic against a register-level model.
// Build with TOILET_REG_CNT_EN defined to exercise the counter option.
module tb_toilet_reg_if;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;
`ifdef TOILET_REG_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif
    localparam int CMAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              bus_sel;
    logic              bus_wr;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ready;
    logic              reg_user_en, reg_spray_en, reg_spray_mode, reg_auto_dis_en, reg_de_ur;
    logic              irq;
    logic [4:0]        st;

    always #5 clk = ~clk;

    toilet_reg_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .bus_sel          (bus_sel),
        .bus_wr           (bus_wr),
        .bus_addr         (bus_addr),
        .bus_wdata        (bus_wdata),
        .bus_rdata        (bus_rdata),
        .bus_ready        (bus_ready),
        .reg_user_en      (reg_user_en),
        .reg_spray_en     (reg_spray_en),
        .reg_spray_mode   (reg_spray_mode),
        .reg_auto_dis_en  (reg_auto_dis_en),
        .reg_de_ur        (reg_de_ur),
        .led_user         (st[0]),
        .spray_an         (st[1]),
        .user_flushes     (st[2]),
        .dis_ur           (st[3]),
        .count_spray_done (st[4]),
        .irq              (irq)
    );

    int checks   = 0;
    int failures = 0;
    bit rnd_stat = 1'b0;

    // Register-level reference state.
    int m_ctrl, m_event, m_irqen, m_fcnt, m_scnt, m_rdata;
    int m_stat, m_stat_prev;
    bit m_ready, m_irq, m_busy;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_read(input int a);
        case (a)
            0: return m_ctrl;
            1: return m_stat;
            2: return m_event;
            3: return m_irqen;
            4: return CNT_ON ? m_fcnt : 0;
            5: return CNT_ON ? m_scnt : 0;
            default: return 0;
        endcase
    endfunction

    task automatic model_edge();
        bit acc, fe, se, fclr, sclr;
        int a, w1c, sat;
        if (!reset_n) begin
            m_ctrl = 0; m_event = 0; m_irqen = 0; m_fcnt = 0; m_scnt = 0; m_rdata = 0;
            m_stat = 0; m_stat_prev = 0; m_ready = 0; m_irq = 0; m_busy = 0;
            return;
        end
        acc  = bus_sel && !m_busy;
        a    = int'(bus_addr[2:0]);
        fe   = m_stat[2] && !m_stat_prev[2];
        se   = m_stat[4] && !m_stat_prev[4];
        w1c  = 0; fclr = 0; sclr = 0; sat = 0;
        m_irq = ((m_event & m_irqen) != 0);
        if (acc && !bus_wr) m_rdata = model_read(a);
        if (acc && bus_wr) begin
            case (a)
                0: m_ctrl  = int'(bus_wdata) & 'h1F;
                2: w1c     = int'(bus_wdata) & 'h7;
                3: m_irqen = int'(bus_wdata) & (CNT_ON ? 'h7 : 'h3);
                4: fclr    = CNT_ON;
                5: sclr    = CNT_ON;
                default: ;
            endcase
        end
        if (CNT_ON) begin
            if (fclr)    m_fcnt = fe ? 1 : 0;
            else if (fe) begin if (m_fcnt == CMAX) sat = 4; else m_fcnt++; end
            if (sclr)    m_scnt = se ? 1 : 0;
            else if (se) begin if (m_scnt == CMAX) sat = 4; else m_scnt++; end
        end
        m_event = (m_event & ~w1c) | (fe ? 1 : 0) | (se ? 2 : 0) | sat;
        m_ready = acc;
        m_busy  = acc ? 1'b1 : (bus_sel ? m_busy : 1'b0);
        m_stat_prev = m_stat;
        m_stat      = int'(st);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_val("ctrl_out", int'({reg_de_ur, reg_auto_dis_en, reg_spray_mode, reg_spray_en, reg_user_en}), m_ctrl);
        check_val("ready", int'(bus_ready), int'(m_ready));
        check_val("irq", int'(irq), int'(m_irq));
        if (m_ready) check_val("rdata", int'(bus_rdata), m_rdata);
        if (rnd_stat)
            for (int i = 0; i < 5; i++)
                if ($urandom_range(3) == 0) st[i] = ~st[i];
    endtask

    task automatic bus_write(input int a, input int d);
        bus_sel = 1'b1; bus_wr = 1'b1; bus_addr = a[ADDR_W-1:0]; bus_wdata = d[DATA_W-1:0];
        cyc();
        bus_sel = 1'b0; bus_wr = 1'b0;
        cyc();
    endtask

    task automatic bus_read(input int a, output int d);
        bus_sel = 1'b1; bus_wr = 1'b0; bus_addr = a[ADDR_W-1:0];
        cyc();
        d = int'(bus_rdata);
        bus_sel = 1'b0;
        cyc();
    endtask

    task automatic pulse(input int bitn, input int n);
        for (int k = 0; k < n; k++) begin
            st[bitn] = 1'b1; cyc();
            st[bitn] = 1'b0; cyc();
        end
    endtask

    initial begin
        int d;
        int pulses;
        reset_n = 1'b0; bus_sel = 1'b0; bus_wr = 1'b0; bus_addr = '0; bus_wdata = '0; st = '0;
        repeat (3) cyc();
        check_val("rst_rdata", int'(bus_rdata), 0);
        check_val("rst_ready", int'(bus_ready), 0);
        reset_n = 1'b1;
        cyc();

        bus_write(0, 'h1F);
        check_val("ctrl_1f_out", int'({reg_de_ur, reg_auto_dis_en, reg_spray_mode, reg_spray_en, reg_user_en}), 'h1F);
        bus_read(0, d);
        check_val("rd_ctrl", d, 'h1F);

        pulse(2, 3);
        repeat (2) cyc();
        bus_read(2, d);
        check_val("event_flush", d, 'h01);
`ifdef TOILET_REG_CNT_EN
        bus_read(4, d);
        check_val("flush_cnt3", d, 3);
`endif
        bus_write(2, 'h01);
        bus_read(2, d);
        check_val("event_w1c", d, 0);
        st[2] = 1'b1;
        repeat (10) cyc();
        st[2] = 1'b0;
        repeat (2) cyc();
`ifdef TOILET_REG_CNT_EN
        bus_read(4, d);
        check_val("flush_cnt_held", d, 4);
`endif
        bus_write(2, 7);

        bus_write(3, 'h02);
        st[4] = 1'b1;
        cyc(); cyc();
        check_val("irq_lat2", int'(irq), 0);
        cyc();
        check_val("irq_lat3", int'(irq), 1);
        st[4] = 1'b0;
        bus_write(2, 'h02);
        check_val("irq_cleared", int'(irq), 0);
        pulse(2, 1);
        repeat (3) cyc();
        check_val("irq_masked", int'(irq), 0);
        bus_write(2, 7);

`ifdef TOILET_REG_CNT_EN
        bus_write(5, 0);
        pulse(4, 256);
        repeat (2) cyc();
        bus_read(5, d);
        check_val("spray_sat", d, 'hFF);
        bus_read(2, d);
        check_val("event_sat", d, 'h06);
        bus_write(5, 0);
        bus_read(5, d);
        check_val("spray_clr", d, 0);
        st[4] = 1'b1;
        cyc();
        bus_write(5, 0);
        st[4] = 1'b0;
        bus_read(5, d);
        check_val("spray_clr_edge", d, 1);
        bus_write(2, 7);
`else
        bus_read(4, d);
        check_val("rd_4_nocnt", d, 0);
        bus_read(5, d);
        check_val("rd_5_nocnt", d, 0);
        bus_write(3, 7);
        bus_read(3, d);
        check_val("irq_en_nocnt", d, 3);
`endif

        pulses = 0;
        bus_sel = 1'b1; bus_wr = 1'b1; bus_addr = '0; bus_wdata = 8'h0A;
        for (int k = 0; k < 5; k++) begin
            cyc();
            if (bus_ready) pulses++;
            bus_wdata = 8'h15;
        end
        bus_sel = 1'b0; bus_wr = 1'b0;
        cyc();
        if (bus_ready) pulses++;
        check_val("hold_pulses", pulses, 1);
        bus_read(0, d);
        check_val("hold_ctrl", d, 'h0A);

        st[2] = 1'b1;
        cyc();
        bus_write(2, 'h01);
        st[2] = 1'b0;
        bus_read(2, d);
        check_val("w1c_race", d & 1, 1);
        bus_write(2, 7);
        st[2] = 1'b1;
        cyc();
        bus_read(2, d);
        check_val("rd_preset", d, 0);
        st[2] = 1'b0;
        bus_read(2, d);
        check_val("rd_postset", d, 1);
        bus_write(2, 7);
        bus_read(7, d);
        check_val("unmapped7", d, 0);

        bus_sel = 1'b1; bus_wr = 1'b1; bus_addr = '0; bus_wdata = 8'h1F;
        repeat (3) cyc();
        reset_n = 1'b0;
        repeat (2) cyc();
        bus_sel = 1'b0; bus_wr = 1'b0; reset_n = 1'b1;
        repeat (2) cyc();
        check_val("rst_wait_ready", int'(bus_ready), 0);
        bus_read(0, d);
        check_val("rst_wait_ctrl", d, 0);

        rnd_stat = 1'b1;
        for (int k = 0; k < 400; k++) begin
            int op, a, dv;
            op = int'($urandom_range(3));
            a  = int'($urandom_range(15));
            dv = int'($urandom_range(255));
            case (op)
                2:       bus_write(a, dv);
                3:       bus_read(a, d);
                default: cyc();
            endcase
        end
        rnd_stat = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
